// File: rtl/bus_decode_pkg.sv
// bus_decode_pkg: ctrl bit positions, config register offsets and wait-state FSM states
package bus_decode_pkg;
  localparam int CTRL_EN = 0;
  localparam int CTRL_QQ = 1;
  localparam int CTRL_EXT = 2;
  localparam int CTRL_WS_LSB = 3;
  localparam int CTRL_WS_W = 3;
  localparam logic [1:0] OFF_BASE = 2'd0;
  localparam logic [1:0] OFF_LIMIT = 2'd1;
  localparam logic [1:0] OFF_CTRL = 2'd2;
  typedef enum logic [1:0] {IDLE, WAIT, HOLD} ws_state_t;
endpackage

// File: rtl/ws_timer.sv
// ws_timer: wait-state FSM that holds mrdy low for ws clocks after a bus cycle starts
module ws_timer
  import bus_decode_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       enable,
  input  logic [2:0] ws,
  output logic       mrdy
);
  ws_state_t state;
  logic [2:0] cnt;
  always_ff @(posedge clk)
    if (rst) begin
      state <= IDLE;
      cnt <= 3'd0;
      mrdy <= 1'b1;
    end else
      case (state)
        IDLE: if (start) begin
          state <= ws != 3'd0 ? WAIT : HOLD;
          cnt <= ws;
          mrdy <= ws == 3'd0;
        end
        WAIT: if (!enable || cnt == 3'd1) begin
          state <= enable ? HOLD : IDLE;
          mrdy <= 1'b1;
        end else begin
          cnt <= cnt - 3'd1;
          mrdy <= 1'b0;
        end
        HOLD: begin
          mrdy <= 1'b1;
          if (!enable) state <= IDLE;
        end
        default: begin
          state <= IDLE;
          mrdy <= 1'b1;
        end
      endcase
endmodule

// File: rtl/bus_region_decoder.sv
// bus_region_decoder: 6809 page-granular region decoder with a writable config window
module bus_region_decoder
  import bus_decode_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int N_REG = 4,
  parameter logic [ADDR_W-1:0] CFG_BASE = ADDR_W'(16'hA010),
  parameter logic [N_REG*8-1:0] RST_BASE = (N_REG*8)'(16'h3010),
  parameter logic [N_REG*8-1:0] RST_LIMIT = (N_REG*8)'(16'h3F1F),
  parameter logic [N_REG*8-1:0] RST_CTRL = (N_REG*8)'(16'h0701)
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic [ADDR_W-1:0] i_address,
  input  logic              i_enable,
  input  logic              i_Q,
  input  logic              i_rw,
  input  logic [7:0]        i_data,
  input  logic [N_REG-1:0]  i_ext_grant_n,
  output logic [N_REG-1:0]  o_ce,
  output logic              o_cfg_ce,
  output logic [7:0]        o_cfg_rdata,
  output logic              o_hit,
  output logic              o_mrdy
);
  logic [7:0] base [N_REG];
  logic [7:0] limit [N_REG];
  logic [5:0] ctrl [N_REG];
  logic en_q, start, wr;
  logic [7:0] page, rdata;
  logic [ADDR_W-1:0] off;
  logic [N_REG-1:0] raw;
  logic [2:0] ws;
  assign page = i_address[ADDR_W-1 -: 8];
  assign off = i_address - CFG_BASE;
  assign o_cfg_ce = i_enable && i_address >= CFG_BASE && off < ADDR_W'(4 * N_REG);
  always_comb begin
    raw = '0;
    for (int i = 0; i < N_REG; i++)
      raw[i] = i_enable && ctrl[i][CTRL_EN] && page >= base[i] && page <= limit[i]
        && (!ctrl[i][CTRL_QQ] || i_Q) && (!ctrl[i][CTRL_EXT] || i_ext_grant_n[i]);
  end
  // isolating the lowest set bit keeps o_ce one-hot; the config window masks everything
  assign o_ce = o_cfg_ce ? '0 : raw & -raw;
  assign o_hit = |o_ce || o_cfg_ce;
  always_comb begin
    ws = 3'd0;
    rdata = 8'h00;
    for (int i = 0; i < N_REG; i++) begin
      if (o_ce[i]) ws = ctrl[i][CTRL_WS_LSB +: CTRL_WS_W];
      if (off[4:2] == 3'(i))
        rdata = off[1:0] == OFF_BASE ? base[i] : off[1:0] == OFF_LIMIT ? limit[i] :
                off[1:0] == OFF_CTRL ? {2'b00, ctrl[i]} : 8'h00;
    end
  end
  assign o_cfg_rdata = o_cfg_ce ? rdata : 8'h00;
  assign start = i_enable && !en_q;
  assign wr = start && !i_rw && o_cfg_ce;
  always_ff @(posedge i_clk)
    if (i_reset) begin
      en_q <= 1'b0;
      for (int i = 0; i < N_REG; i++) begin
        base[i] <= RST_BASE[8*i +: 8];
        limit[i] <= RST_LIMIT[8*i +: 8];
        ctrl[i] <= RST_CTRL[8*i +: 6];
      end
    end else begin
      en_q <= i_enable;
      for (int i = 0; i < N_REG; i++)
        if (wr && off[4:2] == 3'(i)) begin
          if (off[1:0] == OFF_BASE) base[i] <= i_data;
          if (off[1:0] == OFF_LIMIT) limit[i] <= i_data;
          if (off[1:0] == OFF_CTRL) ctrl[i] <= i_data[5:0];
        end
    end
  ws_timer u_ws (
    .clk(i_clk),
    .rst(i_reset),
    .start(start),
    .enable(i_enable),
    .ws(ws),
    .mrdy(o_mrdy)
  );
endmodule

// File: tb/tb_bus_region_decoder.sv
// tb_bus_region_decoder: scoreboard bench for decode priority, config access and wait states
`timescale 1ns/1ps
module tb_bus_region_decoder;
  import bus_decode_pkg::*;
  localparam logic [15:0] CFG = 16'hA010;
  logic i_clk = 1'b0, i_reset = 1'b1, i_enable = 1'b0, i_Q = 1'b1, i_rw = 1'b1;
  logic [15:0] i_address = 16'h0000;
  logic [7:0] i_data = 8'h00;
  logic [3:0] i_ext_grant_n = 4'hF;
  logic [3:0] o_ce;
  logic o_cfg_ce, o_hit, o_mrdy;
  logic [7:0] o_cfg_rdata;
  logic [14:0] obs, e;
  logic [14:0] exp_q[$];
  int n_cmp = 0, n_bad = 0;
  logic [7:0] r_off [7] = '{8'd0, 8'd1, 8'd2, 8'd4, 8'd5, 8'd6, 8'd3};
  logic [7:0] r_val [7] = '{8'h10, 8'h1F, 8'h01, 8'h30, 8'h3F, 8'h07, 8'h00};
  logic [15:0] d_addr [8] = '{16'h1234, 16'h3000, 16'h3000, 16'h3000, 16'h1FFF, 16'h2000, 16'h0FFF, 16'h3FFF};
  logic d_q [8] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
  logic [3:0] d_gnt [8] = '{4'hF, 4'hF, 4'hF, 4'hD, 4'hF, 4'hF, 4'hF, 4'hF};
  logic [3:0] d_ce [8] = '{4'b0001, 4'b0010, 4'b0000, 4'b0000, 4'b0001, 4'b0000, 4'b0000, 4'b0010};
  logic mrdy_seq [7] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};

  always #5 i_clk = ~i_clk;

  bus_region_decoder dut (
    .i_clk(i_clk),
    .i_reset(i_reset),
    .i_address(i_address),
    .i_enable(i_enable),
    .i_Q(i_Q),
    .i_rw(i_rw),
    .i_data(i_data),
    .i_ext_grant_n(i_ext_grant_n),
    .o_ce(o_ce),
    .o_cfg_ce(o_cfg_ce),
    .o_cfg_rdata(o_cfg_rdata),
    .o_hit(o_hit),
    .o_mrdy(o_mrdy)
  );

  assign obs = {o_ce, o_cfg_ce, o_hit, o_mrdy, o_cfg_rdata};

  function automatic logic [14:0] ex(logic [3:0] c, logic f, logic h, logic m, logic [7:0] r);
    return {c, f, h, m, r};
  endfunction

  task automatic setb(input logic [15:0] a, input logic rw, input logic [7:0] d);
    @(negedge i_clk);
    i_address = a; i_rw = rw; i_data = d; i_enable = 1'b1;
    #1;
  endtask

  task automatic endb();
    @(negedge i_clk);
    i_enable = 1'b0; i_rw = 1'b1;
    @(posedge i_clk);
  endtask

  task automatic cfg_write(input logic [7:0] o, input logic [7:0] d);
    setb(CFG + 16'(o), 1'b0, d);
    @(posedge i_clk);
    endb();
  endtask

  task automatic test_reset();
    i_reset = 1'b1;
    repeat (2) @(posedge i_clk);
    @(negedge i_clk);
    i_reset = 1'b0;
    exp_q.push_back(ex(4'b0000, 1'b0, 1'b0, 1'b1, 8'h00));
    #1;
    e = exp_q.pop_front(); n_cmp++;
    if (obs !== e) begin n_bad++; $display("FAIL reset_outputs: got %h want %h", obs, e); end
    n_cmp++;
    if (dut.u_ws.state !== IDLE) begin n_bad++; $display("FAIL reset_state: got %0d want %0d", dut.u_ws.state, IDLE); end
    for (int i = 0; i < 7; i++) begin
      exp_q.push_back(ex(4'b0000, 1'b1, 1'b1, 1'b1, r_val[i]));
      setb(CFG + 16'(r_off[i]), 1'b1, 8'h00);
      e = exp_q.pop_front(); n_cmp++;
      if (obs !== e) begin n_bad++; $display("FAIL reset_table[%0d]: got %h want %h", r_off[i], obs, e); end
      endb();
    end
  endtask

  task automatic test_decode();
    for (int i = 0; i < 8; i++) begin
      i_Q = d_q[i]; i_ext_grant_n = d_gnt[i];
      repeat (3) exp_q.push_back(ex(d_ce[i], 1'b0, |d_ce[i], 1'b1, 8'h00));
      setb(d_addr[i], 1'b1, 8'h00);
      for (int k = 0; k < 3; k++) begin
        e = exp_q.pop_front(); n_cmp++;
        if (obs !== e) begin n_bad++; $display("FAIL decode[%0d] addr %h clk %0d: got %h want %h", i, d_addr[i], k, obs, e); end
        if (k < 2) @(negedge i_clk);
      end
      endb();
    end
    i_Q = 1'b1; i_ext_grant_n = 4'hF;
    @(negedge i_clk);
    i_address = 16'h1234;
    exp_q.push_back(ex(4'b0000, 1'b0, 1'b0, 1'b1, 8'h00));
    #1;
    e = exp_q.pop_front(); n_cmp++;
    if (obs !== e) begin n_bad++; $display("FAIL decode_no_enable: got %h want %h", obs, e); end
  endtask

  task automatic test_wait_states();
    cfg_write(8'd2, 8'h19);
    exp_q.push_back(ex(4'b0000, 1'b1, 1'b1, 1'b1, 8'h19));
    setb(CFG + 16'd2, 1'b1, 8'h00);
    e = exp_q.pop_front(); n_cmp++;
    if (obs !== e) begin n_bad++; $display("FAIL ws3_readback: got %h want %h", obs, e); end
    endb();
    for (int k = 0; k < 7; k++) exp_q.push_back(ex(4'b0001, 1'b0, 1'b1, mrdy_seq[k], 8'h00));
    setb(16'h1000, 1'b1, 8'h00);
    for (int k = 0; k < 7; k++) begin
      e = exp_q.pop_front(); n_cmp++;
      if (obs !== e) begin n_bad++; $display("FAIL ws3_seq clk %0d: got %h want %h", k, obs, e); end
      if (k < 6) @(negedge i_clk);
    end
    endb();
    exp_q.push_back(ex(4'b0000, 1'b0, 1'b0, 1'b1, 8'h00));
    @(negedge i_clk); #1;
    e = exp_q.pop_front(); n_cmp++;
    if (obs !== e) begin n_bad++; $display("FAIL ws3_release: got %h want %h", obs, e); end
    n_cmp++;
    if (dut.u_ws.state !== IDLE) begin n_bad++; $display("FAIL ws3_idle: got %0d want %0d", dut.u_ws.state, IDLE); end
  endtask

  task automatic test_overlap();
    cfg_write(8'd8, 8'h10);
    cfg_write(8'd9, 8'h1F);
    cfg_write(8'd10, 8'h01);
    exp_q.push_back(ex(4'b0001, 1'b0, 1'b1, 1'b1, 8'h00));
    setb(16'h1500, 1'b1, 8'h00);
    e = exp_q.pop_front(); n_cmp++;
    if (obs !== e) begin n_bad++; $display("FAIL overlap_lowest: got %h want %h", obs, e); end
    endb();
    cfg_write(8'd2, 8'h00);
    exp_q.push_back(ex(4'b0100, 1'b0, 1'b1, 1'b1, 8'h00));
    setb(16'h1500, 1'b1, 8'h00);
    e = exp_q.pop_front(); n_cmp++;
    if (obs !== e) begin n_bad++; $display("FAIL overlap_region2: got %h want %h", obs, e); end
    endb();
  endtask

  task automatic test_single_write();
    setb(CFG + 16'd4, 1'b0, 8'h55);
    @(posedge i_clk);
    @(negedge i_clk);
    i_data = 8'hAA;
    repeat (3) @(posedge i_clk);
    endb();
    cfg_write(8'd3, 8'hFF);
    exp_q.push_back(ex(4'b0000, 1'b1, 1'b1, 1'b1, 8'h55));
    exp_q.push_back(ex(4'b0000, 1'b1, 1'b1, 1'b1, 8'h00));
    setb(CFG + 16'd4, 1'b1, 8'h00);
    e = exp_q.pop_front(); n_cmp++;
    if (obs !== e) begin n_bad++; $display("FAIL single_write_data: got %h want %h", obs, e); end
    endb();
    setb(CFG + 16'd3, 1'b1, 8'h00);
    e = exp_q.pop_front(); n_cmp++;
    if (obs !== e) begin n_bad++; $display("FAIL reserved_offset: got %h want %h", obs, e); end
    endb();
  endtask

  task automatic test_abort();
    cfg_write(8'd2, 8'h29);
    exp_q.push_back(ex(4'b0001, 1'b0, 1'b1, 1'b1, 8'h00));
    exp_q.push_back(ex(4'b0001, 1'b0, 1'b1, 1'b0, 8'h00));
    exp_q.push_back(ex(4'b0000, 1'b0, 1'b0, 1'b1, 8'h00));
    setb(16'h1000, 1'b1, 8'h00);
    e = exp_q.pop_front(); n_cmp++;
    if (obs !== e) begin n_bad++; $display("FAIL abort_en_start: got %h want %h", obs, e); end
    @(negedge i_clk);
    e = exp_q.pop_front(); n_cmp++;
    if (obs !== e) begin n_bad++; $display("FAIL abort_en_wait: got %h want %h", obs, e); end
    i_enable = 1'b0;
    @(negedge i_clk); #1;
    e = exp_q.pop_front(); n_cmp++;
    if (obs !== e) begin n_bad++; $display("FAIL abort_en_release: got %h want %h", obs, e); end
    n_cmp++;
    if (dut.u_ws.state !== IDLE) begin n_bad++; $display("FAIL abort_en_idle: got %0d want %0d", dut.u_ws.state, IDLE); end
    exp_q.push_back(ex(4'b0001, 1'b0, 1'b1, 1'b1, 8'h00));
    exp_q.push_back(ex(4'b0001, 1'b0, 1'b1, 1'b0, 8'h00));
    exp_q.push_back(ex(4'b0001, 1'b0, 1'b1, 1'b1, 8'h00));
    setb(16'h1000, 1'b1, 8'h00);
    e = exp_q.pop_front(); n_cmp++;
    if (obs !== e) begin n_bad++; $display("FAIL abort_rst_start: got %h want %h", obs, e); end
    @(negedge i_clk);
    e = exp_q.pop_front(); n_cmp++;
    if (obs !== e) begin n_bad++; $display("FAIL abort_rst_wait: got %h want %h", obs, e); end
    i_reset = 1'b1;
    @(negedge i_clk); #1;
    e = exp_q.pop_front(); n_cmp++;
    if (obs !== e) begin n_bad++; $display("FAIL abort_rst_release: got %h want %h", obs, e); end
    n_cmp++;
    if (dut.u_ws.state !== IDLE) begin n_bad++; $display("FAIL abort_rst_idle: got %0d want %0d", dut.u_ws.state, IDLE); end
    i_reset = 1'b0;
    endb();
    exp_q.push_back(ex(4'b0000, 1'b1, 1'b1, 1'b1, 8'h01));
    exp_q.push_back(ex(4'b0000, 1'b1, 1'b1, 1'b1, 8'h30));
    setb(CFG + 16'd2, 1'b1, 8'h00);
    e = exp_q.pop_front(); n_cmp++;
    if (obs !== e) begin n_bad++; $display("FAIL abort_rst_ctrl0: got %h want %h", obs, e); end
    endb();
    setb(CFG + 16'd4, 1'b1, 8'h00);
    e = exp_q.pop_front(); n_cmp++;
    if (obs !== e) begin n_bad++; $display("FAIL abort_rst_base1: got %h want %h", obs, e); end
    endb();
  endtask

  initial begin
    test_reset();
    test_decode();
    test_wait_states();
    test_overlap();
    test_single_write();
    test_abort();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/bus_region_decoder.md
BUS_REGION_DECODER -- requirements
Module: bus_region_decoder

Interface
REQ-001 SHALL take parameter ADDR_W, default 16, meaning CPU address width.
REQ-002 SHALL take parameter N_REG, default 4, meaning number of decoded regions (1..8).
REQ-003 SHALL take parameter CFG_BASE, default 16'hA010, meaning base of the config window (4*N_REG bytes).
REQ-004 SHALL take parameters RST_BASE, RST_LIMIT and RST_CTRL, each N_REG x 8 packed, meaning per-region reset table; region0 defaults to 0x10/0x1F/0x01 (SRAM), region1 to 0x30/0x3F/0x07 (flash), the rest to 0.
REQ-005 SHALL have port i_clk, input, width 1: sole clock.
REQ-006 SHALL have port i_reset, input, width 1: synchronous, active-high reset.
REQ-007 SHALL have port i_address, input, width ADDR_W: 6809 address bus.
REQ-008 SHALL have port i_enable, input, width 1: bus cycle valid (E phase).
REQ-009 SHALL have port i_Q, input, width 1: 6809 Q clock, used for qualification.
REQ-010 SHALL have port i_rw, input, width 1: 1 = read, 0 = write.
REQ-011 SHALL have port i_data, input, width 8: CPU write data.
REQ-012 SHALL have port i_ext_grant_n, input, width N_REG: active-low, meaning an external master (e.g. the FT2232) owns the region.
REQ-013 SHALL have port o_ce, output, width N_REG: one-hot, active-high region chip enables.
REQ-014 SHALL have port o_cfg_ce, output, width 1: config window selected.
REQ-015 SHALL have port o_cfg_rdata, output, width 8: config register read data.
REQ-016 SHALL have port o_hit, output, width 1: high when any o_ce or o_cfg_ce is high.
REQ-017 SHALL have port o_mrdy, output, width 1: memory ready; low stretches the CPU cycle.

Function
REQ-018 SHALL hold per region: base[7:0], limit[7:0], ctrl[7:0]; ctrl bit0 = enable, bit1 = Q-qualify, bit2 = ext-arbitrate, bits5:3 = wait states (0..7), bits 7:6 read as 0.
REQ-019 SHALL match region i when i_enable=1, ctrl.en=1, and base <= i_address[15:8] <= limit, with inclusive page granularity (256 B).
REQ-020 SHALL additionally require i_Q=1 for a match when Q-qualify is set, and i_ext_grant_n[i]=1 when ext-arbitrate is set.
REQ-021 SHALL give the config window priority over all regions; among regions, the lowest index wins, so o_ce is never multi-hot.
REQ-022 SHALL generate o_ce, o_cfg_ce, o_hit and o_cfg_rdata combinationally from the inputs and the current table, with zero latency.
REQ-023 SHALL map config offset 4*i+{0,1,2} to base/limit/ctrl of region i; offset 4*i+3 reads 0 and ignores writes.
REQ-024 SHALL detect cycle start as i_enable=1 with en_q=0 (en_q is i_enable registered).
REQ-025 SHALL commit a config write on the cycle-start edge when i_rw=0 and o_cfg_ce=1, exactly once per bus cycle, with the new value visible the following clock.
REQ-026 SHALL implement a wait-state FSM with states IDLE, WAIT and HOLD.
REQ-027 In IDLE, on cycle start with winning region ws>0, SHALL load counter=ws and go to WAIT; with ws=0 or no region hit, SHALL go to HOLD.
REQ-028 In WAIT, SHALL drive o_mrdy=0 and decrement each clock; at count 1, SHALL go to HOLD. o_mrdy is therefore low for exactly ws clocks, starting the clock after cycle start.
REQ-029 In HOLD, SHALL drive o_mrdy=1; when i_enable=0, SHALL go to IDLE.
REQ-030 SHALL treat i_enable=0 during WAIT as an abort: go to IDLE, o_mrdy=1 next clock.
REQ-031 SHALL not alter a running WAIT count when a config write changes the region's ws; the change applies to the next cycle.
REQ-032 SHALL drive o_mrdy=1 in IDLE.

Reset
REQ-033 While i_reset=1 at a clock edge, SHALL load the table from RST_* parameters, set FSM=IDLE, counter=0, en_q=0, and o_mrdy=1.
REQ-034 SHALL treat reset asserted mid-WAIT as an abort: o_mrdy=1 on the next clock.

Structure
REQ-035 SHALL place the ctrl bit positions, register offsets and FSM state enum in shared package bus_decode_pkg.
REQ-036 SHALL implement the wait-state FSM and counter as sub-module ws_timer.

Verification
REQ-037 Bench SHALL apply reset, then read 0x1234 -> o_ce=4'b0001 and o_mrdy stays 1; read 0x3000 with i_Q=1 -> o_ce=4'b0010.
REQ-038 Bench SHALL apply 0x3000 with i_Q=0, or with i_ext_grant_n[1]=0 -> o_ce=0 and o_hit=0.
REQ-039 Bench SHALL write 0x19 to CFG_BASE+2 (region0 ws=3), then read 0x1000 -> o_mrdy low exactly 3 clocks, then high until i_enable falls.
REQ-040 Bench SHALL program region2 to 0x10-0x1F, overlapping region0 -> o_ce=4'b0001 (lowest index wins); disable region0 -> o_ce=4'b0100.
REQ-041 Bench SHALL hold i_enable high 4 clocks while writing CFG_BASE+4 -> exactly one write; read back equals data, and offset +3 reads 0.
REQ-042 Bench SHALL drop i_enable, or assert i_reset, after 1 clock of a ws=5 WAIT -> o_mrdy=1 next clock and FSM=IDLE.
